// File: rtl/seq_detector_lock.sv
// seq_detector_lock
//
// Serial pattern detector with a frame-lock tracker. Every accepted bit
// (din_valid=1) is shifted into a PAT_LEN-bit history. A hit occurs when
// the history holds PATTERN and at least PAT_LEN bits have been collected
// since reset (or since the last hit when OVERLAP=0). A small FSM
// (SEARCH / VERIFY / LOCKED) checks that hits recur exactly every PAT_LEN
// accepted bits. It declares lock after LOCK_CNT consecutive in-period hits.
//
// Parameters:
//   PAT_LEN   pattern length in bits (2..16)
//   PATTERN   target pattern, MSB is the first bit received
//   LOCK_CNT  consecutive in-period hits needed for lock (1..15)
//   OVERLAP   1: a match suffix may start the next match
//             0: PAT_LEN fresh bits are needed after a match
//   CNT_W     width of match_cnt
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   din_valid  din is sampled this cycle
//   din        serial data bit
//   match      one-cycle pulse, pattern completed by the last accepted bit
//   locked     level, stream is period-aligned
//   err        one-cycle pulse, period violation while VERIFY or LOCKED
//   match_cnt  saturating count of matches since reset
module seq_detector_lock #(
    parameter int                 PAT_LEN  = 6,
    parameter logic [PAT_LEN-1:0] PATTERN  = 6'b001011,
    parameter int                 LOCK_CNT = 3,
    parameter bit                 OVERLAP  = 1'b1,
    parameter int                 CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    output logic             match,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [FW-1:0]    FILL_FULL  = FW'(PAT_LEN);
    localparam logic [FW-1:0]    PHASE_LAST = FW'(PAT_LEN - 1);
    localparam logic [FW-1:0]    ONE_F      = FW'(1);
    localparam logic [GW-1:0]    GOAL       = GW'(LOCK_CNT);
    localparam logic [GW-1:0]    ONE_G      = GW'(1);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t             state;
    logic [PAT_LEN-1:0] sh;
    logic [PAT_LEN-1:0] sh_next;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_inc;
    logic [FW-1:0]      phase;
    logic [GW-1:0]      good;
    logic               hit;
    logic               boundary;

    // Look-ahead of the history and fill count as they would be after
    // accepting the current bit; a hit is judged on these next values so the
    // match pulse appears one cycle after the completing bit.
    always_comb begin
        sh_next  = (sh << 1) | {{(PAT_LEN-1){1'b0}}, din};
        fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + ONE_F;
        hit      = (fill_inc == FILL_FULL) && (sh_next == PATTERN);
        // The PAT_LEN-th accepted bit after the previous hit.
        boundary = (state != SEARCH) && (phase == PHASE_LAST);
    end

    // Detector datapath, lock FSM and registered outputs. Nothing moves on
    // cycles without din_valid, and the pulses drop back to 0 on them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            sh        <= '0;
            fill      <= '0;
            phase     <= '0;
            good      <= '0;
            match     <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= 1'b0;
            err   <= 1'b0;
            if (din_valid) begin
                sh    <= sh_next;
                fill  <= (hit && !OVERLAP) ? '0 : fill_inc;
                match <= hit;
                if (hit && (match_cnt != '1)) begin
                    match_cnt <= match_cnt + ONE_C;
                end
                // Phase only tracks distance from the last hit once a
                // hit has been seen; in SEARCH it is held at zero.
                if (hit || boundary || (state == SEARCH)) begin
                    phase <= '0;
                end else begin
                    phase <= phase + ONE_F;
                end

                case (state)
                    SEARCH: begin
                        if (hit) begin
                            if (LOCK_CNT == 1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= VERIFY;
                                good  <= ONE_G;
                            end
                        end
                    end
                    VERIFY: begin
                        if (hit && boundary) begin
                            good <= good + ONE_G;
                            if (good == GOAL - ONE_G) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (boundary) begin
                            err   <= 1'b1;
                            state <= SEARCH;
                            good  <= '0;
                        end else if (hit) begin
                            // Early hit: restart verification from this one.
                            err  <= 1'b1;
                            good <= ONE_G;
                        end
                    end
                    LOCKED: begin
                        if (boundary && !hit) begin
                            err    <= 1'b1;
                            state  <= SEARCH;
                            locked <= 1'b0;
                            good   <= '0;
                        end else if (hit && !boundary) begin
                            err <= 1'b1;
                            if (LOCK_CNT != 1) begin
                                state  <= VERIFY;
                                locked <= 1'b0;
                                good   <= ONE_G;
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        good   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/seq_detector_lock.md
# seq_detector_lock

Serial pattern detector and frame-lock tracker; the receive-side counterpart of the team's periodic sequence generator. Samples a 1-bit stream under a valid qualifier and flags every occurrence of a programmable PAT_LEN-bit pattern (default 001011). Tracks whether occurrences arrive with exact period PAT_LEN and declares lock after LOCK_CNT consecutive in-period hits. Sits downstream of the generator, or of any serial link carrying that pattern, as an alignment and health monitor.

## Interface
- PATTERN, 6'b001011, target pattern; MSB is the first bit received.
- PAT_LEN, 6, pattern length in bits; valid range 2..16.
- LOCK_CNT, 3, consecutive in-period matches required to assert locked; valid range 1..15.
- OVERLAP, 1, 1: suffix of a match may start the next match; 0: after a match, PAT_LEN fresh bits are required.
- CNT_W, 8, width of match_cnt.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  din is sampled on this cycle.
- din  in  1  serial data bit.
- match  out  1  one-cycle pulse: pattern completed by the last accepted bit.
- locked  out  1  level: stream is period-aligned.
- err  out  1  one-cycle pulse: period violation while VERIFY or LOCKED.
- match_cnt  out  CNT_W  saturating count of matches since reset.

## Operation
- Shift register sh[PAT_LEN-1:0]: on din_valid, sh <= {sh[PAT_LEN-2:0], din}.
- Fill counter fill (0..PAT_LEN): increments on din_valid, saturating at PAT_LEN. No match is possible while fill < PAT_LEN.
- Hit condition on an accepted bit: fill_next == PAT_LEN and sh_next == PATTERN.
- On a hit with OVERLAP=0, fill clears to 0. With OVERLAP=1, fill is untouched.
- match_cnt increments on each hit and saturates at 2^CNT_W-1.
- phase counter (0..PAT_LEN-1): counts accepted bits since the last hit. It clears on a hit and is meaningful only in VERIFY and LOCKED.
- "Boundary bit" means the accepted bit at which phase would reach PAT_LEN, i.e. the PAT_LEN-th bit after a hit.
- Lock FSM states are SEARCH, VERIFY and LOCKED, with good counter good (0..LOCK_CNT).
  - SEARCH: on hit, if LOCK_CNT==1 go to LOCKED, else go to VERIFY with good=1.
  - VERIFY, hit on boundary bit: good++. If good reaches LOCK_CNT, go to LOCKED.
  - VERIFY, boundary bit without hit: err pulse; go to SEARCH; good=0.
  - VERIFY, hit before boundary (early): err pulse; stay in VERIFY; good=1; phase restarts.
  - LOCKED, hit on boundary bit: stay in LOCKED.
  - LOCKED, boundary bit without hit: err pulse; go to SEARCH.
  - LOCKED, early hit: err pulse; go to VERIFY with good=1 (if LOCK_CNT==1, stay in LOCKED).
- locked = 1 exactly in LOCKED.
- Cycles with din_valid=0 change no state and produce no pulses.

## Timing
- All outputs are registered.
- Reset values: match=0, locked=0, err=0, match_cnt=0. Internally sh=0, fill=0, phase=0, good=0, FSM=SEARCH.
- Latency: a bit accepted in cycle N that completes the pattern gives match=1 in cycle N+1. match_cnt shows the incremented value in cycle N+1.
- A hit that reaches LOCK_CNT raises locked in the same cycle as its match pulse.
- A boundary miss gives err=1 and locked=0 in cycle N+1.
- A boundary hit and the lock transition happen in the same update. err and match can both be 1 only for an early hit.
- Back-to-back din_valid is fully supported: one bit per cycle with no bubbles required.
- Reset asserted mid-stream clears everything on the reset edge, independent of clk. Any pattern partially shifted in before reset never produces a match.

## Test plan
- Reset, then din_valid=0 for 20 cycles -> all outputs stay 0.
- Single 001011 with din_valid=1 only on every 3rd cycle -> exactly one match pulse, one cycle after the 6th valid bit; match_cnt=1; locked=0.
- Continuous repeating 001011 stream, 1 bit/cycle -> match every 6 cycles; locked rises with the 3rd match; err never fires.
- While locked, flip bit 4 of one period -> no match for that period; err=1 and locked=0 one cycle after its 6th bit. Clean periods resume: locked again after 3 more matches.
- Prefix garbage 0001011 then silence -> one match (false prefix ignored). Repeat with OVERLAP=0 and stream 001011001011 -> two matches.
- CNT_W=2, 5 clean periods -> match_cnt reads 1,2,3,3,3. Assert rst in the middle of period 6 -> all outputs are 0 immediately, and the first match after release needs a full 6 new bits.
